// File: rtl/uart_frame_parser.sv
// Command-frame assembler between uart_rx and uart_reg_mapper: header/length/checksum
// validation with inter-byte timeout. Define UART_FRAME_PARSER_ACK_EN to add the ACK/NAK byte request.
module uart_frame_parser #(
    parameter logic [7:0] _HDR0        = 8'hAA,
    parameter logic [7:0] _HDR1        = 8'h55,
    parameter int         _MAX_LEN     = 10,
    parameter int         _TIMEOUT_CYC = 50000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] func_reg,
    output logic [7:0] rev_data1,
    output logic [7:0] rev_data2,
    output logic [7:0] rev_data3,
    output logic [7:0] rev_data4,
    output logic [7:0] rev_data5,
    output logic [7:0] rev_data6,
    output logic [7:0] rev_data7,
    output logic [7:0] rev_data8,
    output logic [7:0] rev_data9,
    output logic [7:0] rev_data10,
    output logic       pack_done,
    output logic       chk_err,
    output logic       frm_err,
`ifdef UART_FRAME_PARSER_ACK_EN
    output logic [7:0] tx_byte,
    output logic       tx_req,
`endif
    output logic       busy
);

    localparam int NSLOT = 10;
    localparam int CW    = $clog2(NSLOT);
    localparam int TW    = $clog2(_TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_FUNC,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t                     state, state_nxt;
    logic [7:0]                 shd_func;
    logic [NSLOT-1:0][7:0]      shd;
    logic [NSLOT-1:0][7:0]      rev_q;
    logic [7:0]                 sum;
    logic [7:0]                 len;
    logic [CW-1:0]              cnt;
    logic [TW-1:0]              tmo_cnt;
    logic                       tmo_hit;
    logic                       len_ok;
    logic                       good;
    logic                       bad_csum;
    logic                       ferr;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // A timeout only fires on a cycle with no byte, so it never races a real transition.
    always_comb begin
        state_nxt = state;
        len_ok    = 1'b0;
        good      = 1'b0;
        bad_csum  = 1'b0;
        ferr      = 1'b0;
        tmo_hit   = (state != S_IDLE) && !rx_valid && (tmo_cnt == TW'(_TIMEOUT_CYC - 1));
        if (tmo_hit) begin
            state_nxt = S_IDLE;
            ferr      = 1'b1;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: if (rx_data == _HDR0) state_nxt = S_HDR1;
                S_HDR1: begin
                    if (rx_data == _HDR1)      state_nxt = S_FUNC;
                    else if (rx_data != _HDR0) state_nxt = S_IDLE;
                end
                S_FUNC: state_nxt = S_LEN;
                S_LEN: begin
                    if (rx_data != 8'd0 && rx_data <= 8'(_MAX_LEN)) begin
                        state_nxt = S_DATA;
                        len_ok    = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        ferr      = 1'b1;
                    end
                end
                S_DATA: if ((8'(cnt) + 8'd1) == len) state_nxt = S_CSUM;
                S_CSUM: begin
                    state_nxt = S_IDLE;
                    if (rx_data == sum) good     = 1'b1;
                    else                bad_csum = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            shd_func  <= '0;
            shd       <= '0;
            rev_q     <= '0;
            func_reg  <= '0;
            sum       <= '0;
            len       <= '0;
            cnt       <= '0;
            tmo_cnt   <= '0;
            pack_done <= 1'b0;
            chk_err   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            pack_done <= good;
            chk_err   <= bad_csum;
            frm_err   <= ferr;
            if (state == S_IDLE || rx_valid || tmo_hit) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + 1'b1;
            if (rx_valid) begin
                case (state)
                    S_FUNC: begin
                        shd_func <= rx_data;
                        sum      <= rx_data;
                    end
                    S_LEN: begin
                        sum <= sum + rx_data;
                        len <= rx_data;
                        cnt <= '0;
                        // Clearing every slot leaves the ones above LEN at zero once DATA fills the rest.
                        if (len_ok) shd <= '0;
                    end
                    S_DATA: begin
                        shd[cnt] <= rx_data;
                        sum      <= sum + rx_data;
                        cnt      <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (good) begin
                func_reg <= shd_func;
                rev_q    <= shd;
            end
        end
    end

`ifdef UART_FRAME_PARSER_ACK_EN
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte <= '0;
            tx_req  <= 1'b0;
        end else begin
            tx_req <= good | bad_csum | ferr;
            if (good)                 tx_byte <= 8'h06;
            else if (bad_csum | ferr) tx_byte <= 8'h15;
        end
    end
`endif

    assign busy       = (state != S_IDLE);
    assign rev_data1  = rev_q[0];
    assign rev_data2  = rev_q[1];
    assign rev_data3  = rev_q[2];
    assign rev_data4  = rev_q[3];
    assign rev_data5  = rev_q[4];
    assign rev_data6  = rev_q[5];
    assign rev_data7  = rev_q[6];
    assign rev_data8  = rev_q[7];
    assign rev_data9  = rev_q[8];
    assign rev_data10 = rev_q[9];

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized self-checking bench for uart_frame_parser against a frame-level reference model.
module tb_uart_frame_parser;

    logic       clk_50M = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] func_reg;
    logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
    logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
    logic       pack_done, chk_err, frm_err, busy;

    uart_frame_parser dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .func_reg(func_reg),
        .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3),
        .rev_data4(rev_data4), .rev_data5(rev_data5), .rev_data6(rev_data6),
        .rev_data7(rev_data7), .rev_data8(rev_data8), .rev_data9(rev_data9),
        .rev_data10(rev_data10),
        .pack_done(pack_done), .chk_err(chk_err), .frm_err(frm_err), .busy(busy)
    );

    always #10 clk_50M = ~clk_50M;

    int total = 0;
    int bad = 0;
    int n_pack = 0, n_chk = 0, n_frm = 0, n_wide = 0, n_excl = 0;
    logic prev_p = 1'b0, prev_c = 1'b0, prev_f = 1'b0;

    // Reference model: the last accepted frame.
    logic [7:0] exp_func;
    logic [7:0] exp_rev [10];

    always @(negedge clk_50M) begin
        if (pack_done) n_pack++;
        if (chk_err)   n_chk++;
        if (frm_err)   n_frm++;
        if ((pack_done && prev_p) || (chk_err && prev_c) || (frm_err && prev_f)) n_wide++;
        if (int'(pack_done) + int'(chk_err) + int'(frm_err) > 1) n_excl++;
        prev_p = pack_done;
        prev_c = chk_err;
        prev_f = frm_err;
    end

    function automatic logic [79:0] rev_vec();
        return {rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
                rev_data6, rev_data7, rev_data8, rev_data9, rev_data10};
    endfunction

    function automatic logic [79:0] exp_vec();
        logic [79:0] v;
        for (int i = 0; i < 10; i++) v[79-8*i -: 8] = exp_rev[i];
        return v;
    endfunction

    function automatic void model_clear();
        exp_func = 8'h00;
        for (int i = 0; i < 10; i++) exp_rev[i] = 8'h00;
    endfunction

    function automatic void model_accept(input logic [7:0] f, input int len, input logic [7:0] pl [10]);
        exp_func = f;
        for (int i = 0; i < 10; i++) exp_rev[i] = (i < len) ? pl[i] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap);
        send_byte(b);
        if (gap > 0) idle($urandom_range(0, gap));
    endtask

    // Full frame; checksum is the plain modulo-256 sum plus cdelta (0 = correct).
    task automatic send_frame(input logic [7:0] f, input int len, input logic [7:0] pl [10],
                              input logic [7:0] cdelta, input int gap);
        int s;
        s = int'(f) + len;
        send_gap(8'hAA, gap);
        send_gap(8'h55, gap);
        send_gap(f, gap);
        send_gap(8'(len), gap);
        for (int i = 0; i < len; i++) begin
            send_gap(pl[i], gap);
            s += int'(pl[i]);
        end
        send_byte(8'(s % 256) + cdelta);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        total++;
        if ({func_reg, rev_vec(), pack_done, chk_err, frm_err, busy} !== 92'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h busy=%b required all zero", rev_vec(), busy);
        end
        rst_n = 1'b1;
        idle(2);
        model_clear();
        total++;
        if (func_reg !== exp_func || rev_vec() !== exp_vec() || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release func=%h rev=%h busy=%b required zero", func_reg, rev_vec(), busy);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] pl [10];
        int p0;
        pl = '{8'h02, 8'h11, 8'h00, 8'h20, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        p0 = n_pack;
        send_frame(8'h01, 10, pl, 8'h00, 0);
        model_accept(8'h01, 10, pl);
        idle(2);
        total++;
        if (n_pack - p0 !== 1) begin
            bad++;
            $display("FAIL good_pack_done got=%0d required=1", n_pack - p0);
        end
        total++;
        if (func_reg !== exp_func || rev_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL good_outputs got=%h/%h required=%h/%h", func_reg, rev_vec(), exp_func, exp_vec());
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] pl [10];
        int p0, c0;
        pl = '{8'h02, 8'h11, 8'h00, 8'h20, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        p0 = n_pack;
        c0 = n_chk;
        send_frame(8'h01, 10, pl, 8'h01, 0);
        idle(2);
        total++;
        if (n_chk - c0 !== 1 || n_pack - p0 !== 0) begin
            bad++;
            $display("FAIL bad_csum_pulses got chk=%0d pack=%0d required 1/0", n_chk - c0, n_pack - p0);
        end
        total++;
        if (func_reg !== exp_func || rev_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL bad_csum_hold got=%h/%h required=%h/%h", func_reg, rev_vec(), exp_func, exp_vec());
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] pl [10];
        int p0;
        pl = '{8'h03, 8'h01, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
        p0 = n_pack;
        send_frame(8'h02, 2, pl, 8'h00, 0);
        model_accept(8'h02, 2, pl);
        idle(2);
        total++;
        if (n_pack - p0 !== 1 || func_reg !== exp_func || rev_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL short_frame got pack=%0d %h/%h required 1 %h/%h",
                     n_pack - p0, func_reg, rev_vec(), exp_func, exp_vec());
        end
    endtask

    task automatic test_len_err();
        logic [7:0] lens [2];
        logic [7:0] pl [10];
        int f0, p0;
        lens = '{8'h00, 8'h0B};
        for (int k = 0; k < 2; k++) begin
            f0 = n_frm;
            send_byte(8'hAA);
            send_byte(8'h55);
            send_byte(8'h07);
            send_byte(lens[k]);
            idle(2);
            total++;
            if (n_frm - f0 !== 1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL len_err_%h got frm=%0d busy=%b required 1/0", lens[k], n_frm - f0, busy);
            end
        end
        pl = '{8'h44, 8'h09, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p0 = n_pack;
        send_frame(8'h05, 3, pl, 8'h00, 0);
        model_accept(8'h05, 3, pl);
        idle(2);
        total++;
        if (n_pack - p0 !== 1 || func_reg !== exp_func || rev_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL len_err_recover got pack=%0d %h/%h required 1 %h/%h",
                     n_pack - p0, func_reg, rev_vec(), exp_func, exp_vec());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] pl [10];
        int f0, p0, waited;
        f0 = n_frm;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        idle(49900);
        total++;
        if (n_frm - f0 !== 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early got frm=%0d busy=%b required 0/1", n_frm - f0, busy);
        end
        waited = 0;
        while (busy && waited < 300) begin
            tick();
            waited++;
        end
        idle(3);
        total++;
        if (n_frm - f0 !== 1 || busy !== 1'b0 || waited < 95 || waited > 105) begin
            bad++;
            $display("FAIL timeout_fire got frm=%0d busy=%b after=%0d required 1/0/~100",
                     n_frm - f0, busy, waited);
        end
        pl = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p0 = n_pack;
        send_byte(8'hAA);
        send_frame(8'h02, 1, pl, 8'h00, 0);
        model_accept(8'h02, 1, pl);
        idle(2);
        total++;
        if (n_pack - p0 !== 1 || func_reg !== exp_func || rev_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL resync got pack=%0d %h/%h required 1 %h/%h",
                     n_pack - p0, func_reg, rev_vec(), exp_func, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        int p0, c0, f0;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h03);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        p0 = n_pack; c0 = n_chk; f0 = n_frm;
        rst_n = 1'b0;
        idle(2);
        model_clear();
        total++;
        if (func_reg !== exp_func || rev_vec() !== exp_vec() || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%h/%h busy=%b required zero", func_reg, rev_vec(), busy);
        end
        rst_n = 1'b1;
        idle(3);
        total++;
        if (n_pack != p0 || n_chk != c0 || n_frm != f0) begin
            bad++;
            $display("FAIL reset_mid_pulses got %0d/%0d/%0d extra pulses required none",
                     n_pack - p0, n_chk - c0, n_frm - f0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [10];
        logic [7:0] pb [10];
        int p0, w0;
        for (int i = 0; i < 10; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        p0 = n_pack;
        w0 = n_wide;
        send_frame(8'h31, 4, pa, 8'h00, 0);
        send_frame(8'h32, 7, pb, 8'h00, 0);
        model_accept(8'h32, 7, pb);
        idle(2);
        total++;
        if (n_pack - p0 !== 2 || n_wide != w0) begin
            bad++;
            $display("FAIL back_to_back got pack=%0d wide=%0d required 2/0", n_pack - p0, n_wide - w0);
        end
        total++;
        if (func_reg !== exp_func || rev_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL back_to_back_out got=%h/%h required=%h/%h", func_reg, rev_vec(), exp_func, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] pl [10];
        logic [7:0] f, noise;
        int kind, len, p0, c0, f0, ep, ec, ef;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            f    = 8'($urandom);
            len  = $urandom_range(1, 10);
            for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
            p0 = n_pack; c0 = n_chk; f0 = n_frm;
            ep = 0; ec = 0; ef = 0;
            if ($urandom_range(0, 3) == 0) begin
                noise = 8'($urandom);
                if (noise == 8'hAA) noise = 8'h00;
                send_byte(noise);
            end
            if (kind <= 5) begin
                send_frame(f, len, pl, 8'h00, 3);
                model_accept(f, len, pl);
                ep = 1;
            end else if (kind <= 7) begin
                send_frame(f, len, pl, 8'($urandom_range(1, 255)), 3);
                ec = 1;
            end else begin
                send_byte(8'hAA);
                send_byte(8'h55);
                send_byte(f);
                send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(11, 255)));
                ef = 1;
            end
            idle(2);
            total++;
            if (n_pack - p0 !== ep || n_chk - c0 !== ec || n_frm - f0 !== ef || busy !== 1'b0) begin
                bad++;
                $display("FAIL random_%0d_pulses got %0d/%0d/%0d busy=%b required %0d/%0d/%0d",
                         n, n_pack - p0, n_chk - c0, n_frm - f0, busy, ep, ec, ef);
            end
            total++;
            if (func_reg !== exp_func || rev_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d_out got=%h/%h required=%h/%h",
                         n, func_reg, rev_vec(), exp_func, exp_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_short_frame();
        test_len_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        total++;
        if (n_wide !== 0 || n_excl !== 0) begin
            bad++;
            $display("FAIL pulse_shape got wide=%0d overlap=%0d required 0/0", n_wide, n_excl);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
